// File: rtl/ws2812b_rx_if.sv
// Strip-side bundle for the WS2812B receiver: data line in, decoded pixels and frame status out.
interface ws2812b_rx_if;
    logic        din;
    logic [23:0] data_out;
    logic        valid;
    logic        latch;
    logic [7:0]  pixel_count;
    logic [7:0]  frame_pixels;
    logic        error;
    logic        busy;

    modport master (
        output din,
        input  data_out, valid, latch, pixel_count, frame_pixels, error, busy
    );

    modport slave (
        input  din,
        output data_out, valid, latch, pixel_count, frame_pixels, error, busy
    );
endinterface

// File: rtl/ws2812b_rx.sv
// WS2812B NRZ receiver: classifies high-pulse widths into bits, assembles GRB pixels,
// detects the latch gap and flags over-long highs or partial pixels.
module ws2812b_rx #(
    parameter int T_BIT_THRESH = 38,
    parameter int T_HIGH_MAX   = 128,
    parameter int T_RESET      = 3200,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    ws2812b_rx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, BAD, LOW} state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [22:0]      sr_q;
    logic [4:0]       bit_cnt_q;
    logic [23:0]      data_q;
    logic [7:0]       pc_q, fp_q;
    logic             valid_q, latch_q, error_q;

    logic             rise, fall, bit_d;
    logic [23:0]      pix_d;

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    // cnt holds width-1 at the fall, so +1 counts the edge cycle too
    assign bit_d = (32'(cnt_q) + 32'd1) >= 32'(T_BIT_THRESH);
    assign pix_d = {sr_q, bit_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            fp_q      <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            s1_q    <= bus.din;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            error_q <= 1'b0;

            if (rise || fall)
                cnt_q <= '0;
            else if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE: if (s2_q) state_q <= HIGH;
                HIGH: begin
                    if (fall) begin
                        sr_q    <= pix_d[22:0];
                        state_q <= LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            data_q    <= pix_d;
                            valid_q   <= 1'b1;
                            if (pc_q != 8'hFF) pc_q <= pc_q + 8'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else if (cnt_q == CNT_W'(T_HIGH_MAX - 1)) begin
                        error_q   <= 1'b1;
                        sr_q      <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= BAD;
                    end
                end
                BAD: if (fall) state_q <= LOW;
                LOW: begin
                    if (rise) begin
                        state_q <= HIGH;
                    end else if (cnt_q == CNT_W'(T_RESET - 1)) begin
                        latch_q <= 1'b1;
                        fp_q    <= pc_q;
                        pc_q    <= '0;
                        state_q <= IDLE;
                        // a partial pixel at the gap is dropped and reported
                        if (bit_cnt_q != '0) begin
                            error_q   <= 1'b1;
                            sr_q      <= '0;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out     = data_q;
    assign bus.valid        = valid_q;
    assign bus.latch        = latch_q;
    assign bus.pixel_count  = pc_q;
    assign bus.frame_pixels = fp_q;
    assign bus.error        = error_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx; a second, fast-timed instance covers pixel-count saturation.
module tb_ws2812b_rx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ws2812b_rx_if bus();
    ws2812b_rx_if bus2();

    ws2812b_rx dut (.clk(clk), .reset(reset), .bus(bus));
    ws2812b_rx #(.T_BIT_THRESH(4), .T_HIGH_MAX(16), .T_RESET(64), .CNT_W(16))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0, errors = 0, cyc = 0;
    logic tgt2 = 1'b0;
    int nv, nl, ne, nel, nev, err_cyc, nv2, nl2;
    logic [23:0] last_data, last2;
    logic [7:0]  latch_fp, fp2;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        nv = 0; nl = 0; ne = 0; nel = 0; nev = 0; err_cyc = 0; nv2 = 0; nl2 = 0;
        last_data = '0; last2 = '0; latch_fp = '0; fp2 = '0;
    endtask

    // drive one cycle of line level, then log the output pulses seen after that edge
    task automatic step(input logic v);
        if (tgt2) bus2.din = v; else bus.din = v;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.valid) begin nv++; last_data = bus.data_out; end
        if (bus.latch) begin nl++; latch_fp = bus.frame_pixels; end
        if (bus.error) begin
            ne++; err_cyc = cyc;
            if (bus.latch) nel++;
            if (bus.valid) nev++;
        end
        if (bus2.valid) begin nv2++; last2 = bus2.data_out; end
        if (bus2.latch) begin nl2++; fp2 = bus2.frame_pixels; end
    endtask

    task automatic pulse(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic send_bit(input logic b);
        if (tgt2) pulse(b ? 5 : 2, 2);
        else      pulse(b ? 51 : 26, b ? 29 : 54);
    endtask

    task automatic send_pixel(input logic [23:0] p, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(p[i]);
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        int rise_cyc;
        bus.din = 1'b0; bus2.din = 1'b0; reset = 1'b1;
        clr();
        gap(4);
        chk("rst_data", {8'h0, bus.data_out}, 32'h0);
        chk("rst_pulses", {29'h0, bus.valid, bus.latch, bus.error}, 32'h0);
        chk("rst_counts", {16'h0, bus.pixel_count, bus.frame_pixels}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        reset = 1'b0;
        gap(2);

        // single pixel
        clr();
        send_pixel(24'hA53CF0, 24);
        gap(100);
        chk("px_valid_cnt", nv, 1);
        chk("px_data", {8'h0, last_data}, 32'hA53CF0);
        chk("px_count", {24'h0, bus.pixel_count}, 32'd1);
        gap(3200);
        chk("px_latch_cnt", nl, 1);
        chk("px_frame_pixels", {24'h0, latch_fp}, 32'd1);
        chk("px_count_cleared", {24'h0, bus.pixel_count}, 32'd0);
        chk("px_no_error", ne, 0);
        chk("px_idle", {31'h0, bus.busy}, 32'h0);

        // 37 vs 38 cycle highs, starting with the short one
        clr();
        for (int i = 0; i < 12; i++) begin
            pulse(37, 40);
            pulse(38, 40);
        end
        gap(20);
        chk("thr_valid_cnt", nv, 1);
        chk("thr_data", {8'h0, last_data}, 32'h555555);
        gap(3300);
        chk("thr_latch", nl, 1);

        // over-long high inside pixel 2
        clr();
        send_pixel(24'h123456, 24);
        send_pixel(24'hFFFFFF, 10);
        rise_cyc = cyc;
        pulse(200, 40);
        chk("bad_err_cnt", ne, 1);
        // 3 cycles of sync/edge latency plus 128 high cycles
        chk("bad_err_offset", err_cyc - rise_cyc, 131);
        chk("bad_valid_before", nv, 1);
        send_pixel(24'h0F0F0F, 24);
        gap(3300);
        chk("bad_valid_cnt", nv, 2);
        chk("bad_next_data", {8'h0, last_data}, 32'h0F0F0F);
        chk("bad_err_valid", nev, 0);
        chk("bad_err_total", ne, 1);
        chk("bad_frame_pixels", {24'h0, latch_fp}, 32'd2);

        // partial pixel at the gap
        clr();
        send_pixel(24'hFFC000, 10);
        gap(3300);
        chk("part_latch", nl, 1);
        chk("part_err", ne, 1);
        chk("part_err_with_latch", nel, 1);
        chk("part_no_valid", nv, 0);
        chk("part_frame_pixels", {24'h0, latch_fp}, 32'd0);

        // reset in the middle of a pixel
        clr();
        send_pixel(24'hABCDEF, 12);
        reset = 1'b1;
        gap(2);
        reset = 1'b0;
        gap(1);
        chk("rstmid_busy", {31'h0, bus.busy}, 32'h0);
        chk("rstmid_quiet", nv + nl + ne, 0);
        send_pixel(24'h00FF00, 24);
        gap(100);
        chk("rstmid_valid", nv, 1);
        chk("rstmid_data", {8'h0, last_data}, 32'h00FF00);
        chk("rstmid_no_err", ne + nl, 0);

        // saturation on the fast instance
        clr();
        tgt2 = 1'b1;
        for (int i = 0; i < 300; i++) send_pixel(24'(i), 24);
        gap(10);
        chk("sat_valid_cnt", nv2, 300);
        chk("sat_last_data", {8'h0, last2}, 32'd299);
        chk("sat_count", {24'h0, bus2.pixel_count}, 32'd255);
        gap(80);
        chk("sat_latch", nl2, 1);
        chk("sat_frame_pixels", {24'h0, fp2}, 32'd255);
        chk("sat_count_cleared", {24'h0, bus2.pixel_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
